mem_writeback: RTL
==================

# mem_writeback

Memory/writeback stage that consumes the execute stage's registered result bundle (ALU result, destination register, write-enable, memory/halt flags). It performs data-memory loads and stores with a configurable access latency, stalling the execute stage while an access is in flight. It drives the register-file write port and exposes the last completed value plus its destination tag, which the execute stage uses for forwarding.

## Interface
Parameters:
- DATA_W, 16, width of `block` (data word and memory address source)
- DEPTH, 256, data-memory words (power of two)
- MEM_LAT, 2, load/store latency in cycles, legal range 1..7

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- exe_valid  in  1  bundle below is a valid op this cycle
- exe_result  in  DATA_W  ALU result; memory address for loads/stores
- exe_store_data  in  DATA_W  store data
- exe_reg_addr  in  4  destination register
- exe_reg_write  in  1  op writes a register
- exe_mem_read  in  1  op is a load
- exe_mem_write  in  1  op is a store
- exe_halt  in  1  op is halt
- stall  out  1  upstream must hold its bundle
- wb_en  out  1  register-file write strobe, one-cycle pulse
- wb_addr  out  4  register-file write address
- wb_data  out  DATA_W  register-file write data
- mem_value  out  DATA_W  last completed value (forwarding source)
- mem_reg_addr  out  4  destination of last completed op
- mem_reg_write  out  1  last completed op wrote a register
- halted  out  1  sticky halt indication

## Operation
- States: IDLE, BUSY, HALT.
- IDLE, exe_valid=1: bundle captured (accept edge).
  - exe_halt: → HALT, halted<=1; no writeback, no memory access.
  - non-memory op, or memory op with MEM_LAT=1: completes at accept edge.
  - memory op with MEM_LAT>1: → BUSY, cnt<=MEM_LAT-1.
- BUSY: cnt decrements each edge; the edge where cnt=1 completes the op and returns to IDLE.
- Completion:
  - ALU op: wb_data<=exe_result (captured); wb_en<=reg_write.
  - load: wb_data<=mem[addr]; wb_en<=reg_write.
  - store: mem[addr]<=store_data; wb_en<=0.
  - mem_value<=wb_data value, mem_reg_addr<=dest, mem_reg_write<=wb_en; these hold until the next completion.
- addr = exe_result[log2(DEPTH)-1:0]; upper bits are ignored (wrap).
- exe_mem_read and exe_mem_write both set: treated as a store.
- HALT: absorbing until reset; exe_valid ignored; stall=0.
- stall = (state==BUSY).

## Timing
- Reset (asynchronous): state=IDLE, cnt=0; wb_en, wb_addr, wb_data, mem_value, mem_reg_addr, mem_reg_write, halted, stall all 0. Memory contents are not cleared.
- ALU op: wb_en is high in the cycle after the accept edge.
- Memory op: outputs update on the (MEM_LAT-1)th edge after accept. stall is high for exactly MEM_LAT-1 cycles, starting the cycle after accept.
- A bundle presented while stall=1 is not accepted. It is accepted on the first edge after stall falls, so back-to-back ops lose no cycle beyond MEM_LAT-1.
- Load immediately after a store to the same address returns the new data (store completes first).
- Reset while BUSY: op aborted; store not performed; no wb_en.

## Configuration
- MEM_WRITEBACK_TRACE_EN defined: $display at each completion (op kind, addr, data, dest) and on halt entry.
- Undefined: no display statements.
- Cycle behaviour is identical either way.

## Structure
- Shared package holds `block`, `addr`, a 4-bit register-address typedef, and the state enum (IDLE/BUSY/HALT).
- One sub-module: data_mem (DEPTH x DATA_W, synchronous write, asynchronous read), instantiated once.

## Test plan
- Reset, then ALU op result=0x0042, dest=3, reg_write=1 -> next cycle wb_en=1, wb_addr=3, wb_data=0x0042, mem_value=0x0042, stall never high.
- MEM_LAT=3: store 0x1234 to addr 0x10, then load addr 0x10 dest=5 -> stall high 2 cycles per op; load wb_data=0x1234, wb_en=1; store produces no wb_en.
- Address wrap, DEPTH=256: store 0xBEEF at 0x0105, load at 0x0005 -> wb_data=0xBEEF.
- Halt op followed by valid ALU ops -> halted=1 sticky, no further wb_en, stall=0.
- Assert reset mid-BUSY on a store to 0x20 with 0x5555 -> all outputs 0 at once; later load of 0x20 does not return 0x5555.
- MEM_LAT=1: load then ALU op back-to-back -> stall stays 0; two consecutive wb_en pulses.

Source files
------------

// File: rtl/mem_writeback_pkg.sv
// mem_writeback_pkg: shared types for the memory/writeback stage.
// Revision: 1.0
`default_nettype none

package mem_writeback_pkg;

  localparam int PKG_DATA_W = 16;
  localparam int PKG_DEPTH  = 256;
  localparam int PKG_ADDR_W = $clog2(PKG_DEPTH);

  typedef logic [PKG_DATA_W-1:0] block_t;
  typedef logic [PKG_ADDR_W-1:0] addr_t;
  typedef logic [3:0]            reg_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HALT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_writeback_if.sv
// mem_writeback_if: execute-bundle input and writeback/forwarding outputs.
// Revision: 1.0
`default_nettype none

interface mem_writeback_if
  import mem_writeback_pkg::*;
#(
  parameter int DATA_W = PKG_DATA_W
) ();

  logic              exe_valid;
  logic [DATA_W-1:0] exe_result;
  logic [DATA_W-1:0] exe_store_data;
  reg_addr_t         exe_reg_addr;
  logic              exe_reg_write;
  logic              exe_mem_read;
  logic              exe_mem_write;
  logic              exe_halt;

  logic              stall;
  logic              wb_en;
  reg_addr_t         wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [DATA_W-1:0] mem_value;
  reg_addr_t         mem_reg_addr;
  logic              mem_reg_write;
  logic              halted;

  modport master (
    output exe_valid, exe_result, exe_store_data, exe_reg_addr,
           exe_reg_write, exe_mem_read, exe_mem_write, exe_halt,
    input  stall, wb_en, wb_addr, wb_data, mem_value, mem_reg_addr,
           mem_reg_write, halted
  );

  modport slave (
    input  exe_valid, exe_result, exe_store_data, exe_reg_addr,
           exe_reg_write, exe_mem_read, exe_mem_write, exe_halt,
    output stall, wb_en, wb_addr, wb_data, mem_value, mem_reg_addr,
           mem_reg_write, halted
  );

endinterface

`default_nettype wire

// File: rtl/mem_writeback_data_mem.sv
// data_mem: DEPTH x DATA_W data memory, synchronous write, asynchronous read.
// Revision: 1.0
`default_nettype none

module data_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  wire logic              clk,
  input  wire logic              we_i,
  input  wire logic [AW-1:0]     addr_i,
  input  wire logic [DATA_W-1:0] wdata_i,
  output      logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

`default_nettype wire

// File: rtl/mem_writeback.sv
// mem_writeback: memory/writeback stage with MEM_LAT-cycle data-memory access.
// Optional completion/halt trace: define MEM_WRITEBACK_TRACE_EN. Revision: 1.0
`default_nettype none

module mem_writeback
  import mem_writeback_pkg::*;
#(
  parameter int DATA_W  = PKG_DATA_W,
  parameter int DEPTH   = PKG_DEPTH,
  parameter int MEM_LAT = 2
) (
  input wire logic      clk,
  input wire logic      rst,
  mem_writeback_if.slave bus
);

  localparam int          AW          = $clog2(DEPTH);
  localparam logic [2:0]  LAT_M1      = 3'(MEM_LAT - 1);
  localparam bit          MULTI_CYCLE = (MEM_LAT > 1);

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] op_result_q, op_result_d;
  logic [DATA_W-1:0] op_sdata_q, op_sdata_d;
  reg_addr_t         op_dest_q, op_dest_d;
  logic              op_rw_q, op_rw_d;
  logic              op_rd_q, op_rd_d;
  logic              op_wr_q, op_wr_d;

  logic              wb_en_q, wb_en_d;
  reg_addr_t         wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [DATA_W-1:0] mem_value_q, mem_value_d;
  reg_addr_t         mem_reg_addr_q, mem_reg_addr_d;
  logic              mem_reg_write_q, mem_reg_write_d;
  logic              halted_q, halted_d;

  // In IDLE the op completing is the one on the bus; in BUSY it is the captured one.
  logic              in_busy;
  logic [DATA_W-1:0] cur_result, cur_sdata, rdata;
  reg_addr_t         cur_dest;
  logic              cur_rw, cur_store, cur_load;
  logic              do_complete, mem_we;
  logic [DATA_W-1:0] done_value;
  logic              done_wb_en;

  assign in_busy    = (state_q == BUSY);
  assign cur_result = in_busy ? op_result_q : bus.exe_result;
  assign cur_sdata  = in_busy ? op_sdata_q  : bus.exe_store_data;
  assign cur_dest   = in_busy ? op_dest_q   : bus.exe_reg_addr;
  assign cur_rw     = in_busy ? op_rw_q     : bus.exe_reg_write;
  assign cur_store  = in_busy ? op_wr_q     : bus.exe_mem_write;
  assign cur_load   = (in_busy ? op_rd_q : bus.exe_mem_read) & ~cur_store;

  data_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_data_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .addr_i  (cur_result[AW-1:0]),
    .wdata_i (cur_sdata),
    .rdata_o (rdata)
  );

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    op_result_d     = op_result_q;
    op_sdata_d      = op_sdata_q;
    op_dest_d       = op_dest_q;
    op_rw_d         = op_rw_q;
    op_rd_d         = op_rd_q;
    op_wr_d         = op_wr_q;
    wb_en_d         = 1'b0;
    wb_addr_d       = wb_addr_q;
    wb_data_d       = wb_data_q;
    mem_value_d     = mem_value_q;
    mem_reg_addr_d  = mem_reg_addr_q;
    mem_reg_write_d = mem_reg_write_q;
    halted_d        = halted_q;
    do_complete     = 1'b0;
    mem_we          = 1'b0;
    done_value      = '0;
    done_wb_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.exe_valid) begin
          if (bus.exe_halt) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else begin
            op_result_d = bus.exe_result;
            op_sdata_d  = bus.exe_store_data;
            op_dest_d   = bus.exe_reg_addr;
            op_rw_d     = bus.exe_reg_write;
            op_rd_d     = bus.exe_mem_read;
            op_wr_d     = bus.exe_mem_write;
            if ((bus.exe_mem_read || bus.exe_mem_write) && MULTI_CYCLE) begin
              state_d = BUSY;
              cnt_d   = LAT_M1;
            end else begin
              do_complete = 1'b1;
            end
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          do_complete = 1'b1;
          state_d     = IDLE;
        end
      end
      HALT: ;
      default: state_d = IDLE;
    endcase

    if (do_complete) begin
      if (cur_store) begin
        mem_we     = rst;
        done_value = cur_sdata;
        done_wb_en = 1'b0;
      end else if (cur_load) begin
        done_value = rdata;
        done_wb_en = cur_rw;
      end else begin
        done_value = cur_result;
        done_wb_en = cur_rw;
      end
      wb_en_d         = done_wb_en;
      wb_addr_d       = cur_dest;
      wb_data_d       = done_value;
      mem_value_d     = done_value;
      mem_reg_addr_d  = cur_dest;
      mem_reg_write_d = done_wb_en;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      op_result_q     <= '0;
      op_sdata_q      <= '0;
      op_dest_q       <= '0;
      op_rw_q         <= 1'b0;
      op_rd_q         <= 1'b0;
      op_wr_q         <= 1'b0;
      wb_en_q         <= 1'b0;
      wb_addr_q       <= '0;
      wb_data_q       <= '0;
      mem_value_q     <= '0;
      mem_reg_addr_q  <= '0;
      mem_reg_write_q <= 1'b0;
      halted_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      op_result_q     <= op_result_d;
      op_sdata_q      <= op_sdata_d;
      op_dest_q       <= op_dest_d;
      op_rw_q         <= op_rw_d;
      op_rd_q         <= op_rd_d;
      op_wr_q         <= op_wr_d;
      wb_en_q         <= wb_en_d;
      wb_addr_q       <= wb_addr_d;
      wb_data_q       <= wb_data_d;
      mem_value_q     <= mem_value_d;
      mem_reg_addr_q  <= mem_reg_addr_d;
      mem_reg_write_q <= mem_reg_write_d;
      halted_q        <= halted_d;
    end
  end

`ifdef MEM_WRITEBACK_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      if (do_complete) begin
        $display("mem_writeback: %s addr=0x%0h data=0x%0h dest=%0d",
                 cur_store ? "STORE" : (cur_load ? "LOAD" : "ALU"),
                 cur_result[AW-1:0], done_value, cur_dest);
      end
      if (state_q == IDLE && state_d == HALT) begin
        $display("mem_writeback: HALT entered");
      end
    end
  end
`endif

  assign bus.stall         = in_busy;
  assign bus.wb_en         = wb_en_q;
  assign bus.wb_addr       = wb_addr_q;
  assign bus.wb_data       = wb_data_q;
  assign bus.mem_value     = mem_value_q;
  assign bus.mem_reg_addr  = mem_reg_addr_q;
  assign bus.mem_reg_write = mem_reg_write_q;
  assign bus.halted        = halted_q;

endmodule

`default_nettype wire
